// File: rtl/sram_bist_pkg.sv
// March C- BIST shared types and per-element constants.
// Element table: direction, expected read, write value, ops/address.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    E0 = 3'd0,
    E1 = 3'd1,
    E2 = 3'd2,
    E3 = 3'd3,
    E4 = 3'd4,
    E5 = 3'd5
  } march_elem_e;

  typedef enum logic {
    RD = 1'b0,
    WR = 1'b1
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } bist_state_e;

  function automatic logic elem_down(march_elem_e e);
    case (e)
      E3, E4:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic elem_rd_val(march_elem_e e);
    case (e)
      E2, E4:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic elem_wr_val(march_elem_e e);
    case (e)
      E1, E3:  return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic elem_two_ops(march_elem_e e);
    case (e)
      E1, E2, E3, E4: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  function automatic op_e elem_first_op(march_elem_e e);
    return (e == E0) ? WR : RD;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Loadable up/down word address counter for the March walker.
// Terminal flags come from compares against the element's end points.
module sram_bist_addr_gen #(
  parameter int ADDR_W = 9
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic              load_down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic              first,
  output logic              last
);

  localparam logic [ADDR_W-1:0] TOP = '1;
  localparam logic [ADDR_W-1:0] ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  logic [ADDR_W-1:0] addr_q;
  logic              down_q;

  // load picks the element's start point and direction; step walks
  always_ff @(posedge clock) begin
    if (reset) begin
      addr_q <= '0;
      down_q <= 1'b0;
    end else if (load) begin
      addr_q <= load_down ? TOP : '0;
      down_q <= load_down;
    end else if (step) begin
      addr_q <= down_q ? addr_q - ONE : addr_q + ONE;
    end
  end

  assign addr  = addr_q;
  assign first = addr_q == (down_q ? TOP : '0);
  assign last  = addr_q == (down_q ? '0 : TOP);

endmodule

// File: rtl/sram_march_bist.sv
// March C- initiator for one single-port RW0 SRAM macro.
// Issues one op per cycle, compares reads a cycle later.
module sram_march_bist
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 128,
  parameter int MASK_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  output logic              io_busy,
  output logic              io_done,
  output logic              io_fail,
  output logic [ADDR_W-1:0] io_fail_addr,
  output logic [2:0]        io_fail_elem,
  output logic [ADDR_W-1:0] RW0_addr,
  output logic              RW0_en,
  output logic              RW0_wmode,
  output logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_wdata,
  input  logic [DATA_W-1:0] RW0_rdata
);

  bist_state_e state_q, state_d;
  march_elem_e elem_q, elem_d, elem_nx;
  op_e         op_q, op_d;

  logic              ag_load, ag_load_down, ag_step;
  logic [ADDR_W-1:0] ag_addr;
  logic              ag_first, ag_last;
  logic              unused_first;

  logic              rd_pend_q, rd_exp_q;
  logic [ADDR_W-1:0] rd_addr_q;
  march_elem_e       rd_elem_q;

  logic              fail_q;
  logic [ADDR_W-1:0] fail_addr_q;
  logic [2:0]        fail_elem_q;

  logic issue, accept, cmp_fail;

  sram_bist_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clock    (clock),
    .reset    (reset),
    .load     (ag_load),
    .load_down(ag_load_down),
    .step     (ag_step),
    .addr     (ag_addr),
    .first    (ag_first),
    .last     (ag_last)
  );

  assign unused_first = ag_first;

  assign issue   = state_q == S_RUN;
  assign accept  = state_q == S_IDLE && io_start;
  assign elem_nx = march_elem_e'(elem_q + 3'd1);

  // a read returned last cycle is checked while the next op issues
  assign cmp_fail = rd_pend_q
                 && (state_q == S_RUN || state_q == S_DRAIN)
                 && RW0_rdata != {DATA_W{rd_exp_q}};

  // walk sub-op -> address -> element; a miscompare ends the run
  always_comb begin
    state_d      = state_q;
    elem_d       = elem_q;
    op_d         = op_q;
    ag_load      = 1'b0;
    ag_load_down = 1'b0;
    ag_step      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (io_start) begin
          state_d      = S_RUN;
          elem_d       = E0;
          op_d         = elem_first_op(E0);
          ag_load      = 1'b1;
          ag_load_down = elem_down(E0);
        end
      end
      S_RUN: begin
        if (cmp_fail) begin
          state_d = S_DONE;
        end else if (elem_two_ops(elem_q) && op_q == RD) begin
          op_d = WR;
        end else if (!ag_last) begin
          ag_step = 1'b1;
          op_d    = elem_first_op(elem_q);
        end else if (elem_q == E5) begin
          state_d = S_DRAIN;
        end else begin
          elem_d       = elem_nx;
          op_d         = elem_first_op(elem_nx);
          ag_load      = 1'b1;
          ag_load_down = elem_down(elem_nx);
        end
      end
      S_DRAIN: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // FSM registers plus the one-deep read tracking pipe
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      elem_q    <= E0;
      op_q      <= RD;
      rd_pend_q <= 1'b0;
      rd_exp_q  <= 1'b0;
      rd_addr_q <= '0;
      rd_elem_q <= E0;
    end else begin
      state_q   <= state_d;
      elem_q    <= elem_d;
      op_q      <= op_d;
      rd_pend_q <= issue && op_q == RD;
      rd_exp_q  <= elem_rd_val(elem_q);
      rd_addr_q <= ag_addr;
      rd_elem_q <= elem_q;
    end
  end

  // sticky result: cleared when a run is accepted, first miss kept
  always_ff @(posedge clock) begin
    if (reset) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if (accept) begin
      fail_q      <= 1'b0;
      fail_addr_q <= '0;
      fail_elem_q <= '0;
    end else if (cmp_fail && !fail_q) begin
      fail_q      <= 1'b1;
      fail_addr_q <= rd_addr_q;
      fail_elem_q <= rd_elem_q;
    end
  end

  assign io_busy      = state_q == S_RUN || state_q == S_DRAIN;
  assign io_done      = state_q == S_DONE;
  assign io_fail      = fail_q;
  assign io_fail_addr = fail_addr_q;
  assign io_fail_elem = fail_elem_q;

  assign RW0_en    = issue;
  assign RW0_wmode = issue && op_q == WR;
  assign RW0_addr  = issue ? ag_addr : '0;
  assign RW0_wmask = {MASK_W{RW0_wmode}};
  assign RW0_wdata = RW0_wmode ? {DATA_W{elem_wr_val(elem_q)}} : '0;

endmodule

// File: tb/tb_sram_march_bist.sv
// Bench for sram_march_bist: faulty RW0 SRAM model and a
// March C- reference walker that predicts ops and first failure.
module tb_sram_march_bist;

  localparam int AW = 2;
  localparam int DW = 8;
  localparam int MW = 1;
  localparam int N  = 4;

  typedef struct packed {
    logic          wm;
    logic [AW-1:0] a;
    logic [MW-1:0] m;
    logic [DW-1:0] d;
  } op_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          io_start;
  logic          io_busy, io_done, io_fail;
  logic [AW-1:0] io_fail_addr;
  logic [2:0]    io_fail_elem;
  logic [AW-1:0] RW0_addr;
  logic          RW0_en, RW0_wmode;
  logic [MW-1:0] RW0_wmask;
  logic [DW-1:0] RW0_wdata;
  logic [DW-1:0] RW0_rdata = '0;

  int checks = 0;
  int passed = 0;

  always #5 clock = ~clock;

  sram_march_bist #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .MASK_W(MW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_busy     (io_busy),
    .io_done     (io_done),
    .io_fail     (io_fail),
    .io_fail_addr(io_fail_addr),
    .io_fail_elem(io_fail_elem),
    .RW0_addr    (RW0_addr),
    .RW0_en      (RW0_en),
    .RW0_wmode   (RW0_wmode),
    .RW0_wmask   (RW0_wmask),
    .RW0_wdata   (RW0_wdata),
    .RW0_rdata   (RW0_rdata)
  );

  // fault: mode 1 = stuck bit fb of word fa at fv,
  // mode 2 = writes to fa also land in fb
  int   fmode = 0;
  int   fa = 0;
  int   fb = 0;
  logic fv = 1'b0;

  logic [DW-1:0] sram_mem [N];
  logic [DW-1:0] load_img [N];
  logic          load_mem;

  function automatic logic [DW-1:0] fread(logic [DW-1:0] v, int a);
    logic [DW-1:0] r;
    r = v;
    if (fmode == 1 && a == fa) r[fb] = fv;
    return r;
  endfunction

  logic          l_en, l_wm;
  logic [AW-1:0] l_addr;
  logic [MW-1:0] l_wmask;
  logic [DW-1:0] l_wdata;

  always @(negedge clock) begin
    l_en    <= RW0_en;
    l_wm    <= RW0_wmode;
    l_addr  <= RW0_addr;
    l_wmask <= RW0_wmask;
    l_wdata <= RW0_wdata;
  end

  always @(posedge clock) begin
    if (load_mem) begin
      for (int i = 0; i < N; i++) sram_mem[i] <= load_img[i];
    end else if (l_en) begin
      if (l_wm) begin
        if (l_wmask[0]) begin
          sram_mem[l_addr] <= l_wdata;
          if (fmode == 2 && int'(l_addr) == fa)
            sram_mem[fb] <= l_wdata;
        end
      end else begin
        RW0_rdata <= fread(sram_mem[l_addr], int'(l_addr));
      end
    end
  end

  int  cyc = 0;
  int  busy_cnt = 0;
  int  done_cnt = 0;
  int  ovl_cnt = 0;
  int  last_busy_cyc = 0;
  int  done_cyc = 0;
  op_t log_q[$];

  function automatic op_t mk_op();
    op_t o;
    o.wm = RW0_wmode;
    o.a  = RW0_addr;
    o.m  = RW0_wmask;
    o.d  = RW0_wdata;
    return o;
  endfunction

  always @(negedge clock) begin
    cyc <= cyc + 1;
    if (io_busy) begin
      busy_cnt      <= busy_cnt + 1;
      last_busy_cyc <= cyc;
    end
    if (io_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    if (io_done && io_busy) ovl_cnt <= ovl_cnt + 1;
    if (RW0_en) log_q.push_back(mk_op());
  end

  // reference March C- walk over a copy of the memory
  op_t           exp_q[$];
  logic [DW-1:0] ref_mem [N];
  bit            exp_fail;
  int            exp_addr, exp_elem, exp_nops, exp_busy;

  task automatic build_exp();
    int  rd_of[6] = '{-1, 0, 1, 0, 1, 0};
    int  wr_of[6] = '{0, 1, 0, 1, 0, -1};
    bit  dn[6]    = '{0, 0, 0, 1, 1, 0};
    int  k, fk, a;
    op_t o;
    logic [DW-1:0] pat;
    k  = 0;
    fk = -1;
    exp_q.delete();
    exp_fail = 0;
    exp_addr = 0;
    exp_elem = 0;
    for (int i = 0; i < N; i++) ref_mem[i] = load_img[i];
    for (int e = 0; e < 6; e++) begin
      for (int j = 0; j < N; j++) begin
        a = dn[e] ? N - 1 - j : j;
        if (rd_of[e] >= 0) begin
          pat  = (rd_of[e] == 1) ? '1 : '0;
          o.wm = 1'b0;
          o.a  = a[AW-1:0];
          o.m  = '0;
          o.d  = '0;
          exp_q.push_back(o);
          if (fk < 0 && fread(ref_mem[a], a) !== pat) begin
            fk       = k;
            exp_addr = a;
            exp_elem = e;
          end
          k++;
        end
        if (wr_of[e] >= 0) begin
          pat  = (wr_of[e] == 1) ? '1 : '0;
          o.wm = 1'b1;
          o.a  = a[AW-1:0];
          o.m  = '1;
          o.d  = pat;
          exp_q.push_back(o);
          ref_mem[a] = pat;
          if (fmode == 2 && a == fa) ref_mem[fb] = pat;
          k++;
        end
      end
    end
    if (fk >= 0) begin
      exp_fail = 1;
      exp_busy = fk + 2;
      exp_nops = (fk + 2 < k) ? fk + 2 : k;
    end else begin
      exp_busy = k + 1;
      exp_nops = k;
    end
  endtask

  task automatic tick();
    @(negedge clock);
    #1;
  endtask

  task automatic set_mem();
    for (int i = 0; i < N; i++) load_img[i] = DW'($urandom);
    load_mem = 1'b1;
    tick();
    load_mem = 1'b0;
  endtask

  // start pulse, wait for done, then idle a few cycles
  task automatic do_run(output bit tmo, output int busy,
                        output int base);
    int b0, d0;
    b0   = busy_cnt;
    d0   = done_cnt;
    base = log_q.size();
    tmo  = 1;
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (done_cnt != d0) begin
        tmo = 0;
        break;
      end
    end
    repeat (5) tick();
    busy = busy_cnt - b0;
  endtask

  task automatic test_reset();
    reset    = 1'b1;
    io_start = 1'b0;
    load_mem = 1'b0;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    checks++;
    if ({io_busy, io_done, io_fail, io_fail_addr, io_fail_elem} !== '0)
      $display("FAIL reset_status: got %b want 0",
               {io_busy, io_done, io_fail, io_fail_addr, io_fail_elem});
    else passed++;
    checks++;
    if ({RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata} !== '0)
      $display("FAIL reset_rw0: got %b want 0",
               {RW0_en, RW0_wmode, RW0_addr, RW0_wmask, RW0_wdata});
    else passed++;
  endtask

  task automatic test_clean();
    bit tmo;
    int busy, base, nw, nr, bad, d0, o0;
    fmode = 0;
    set_mem();
    build_exp();
    d0 = done_cnt;
    o0 = ovl_cnt;
    do_run(tmo, busy, base);
    checks++;
    if (tmo) $display("FAIL clean_timeout: no done within bound");
    else passed++;
    checks++;
    if (busy != 41) $display("FAIL clean_busy: got %0d want 41", busy);
    else passed++;
    nw = 0;
    nr = 0;
    for (int i = base; i < log_q.size(); i++)
      if (log_q[i].wm) nw++;
      else nr++;
    checks++;
    if (nw != 20 || nr != 20)
      $display("FAIL clean_ops: got %0d wr %0d rd want 20 wr 20 rd", nw, nr);
    else passed++;
    bad = 0;
    if (log_q.size() - base != exp_nops) bad++;
    else
      for (int i = 0; i < exp_nops; i++)
        if (log_q[base+i] !== exp_q[i]) bad++;
    checks++;
    if (bad != 0) $display("FAIL clean_seq: got %0d bad ops want 0", bad);
    else passed++;
    checks++;
    if (done_cnt - d0 != 1 || done_cyc != last_busy_cyc + 1
        || ovl_cnt != o0)
      $display("FAIL clean_done: got %0d pulses gap %0d want 1 pulse gap 1",
               done_cnt - d0, done_cyc - last_busy_cyc);
    else passed++;
    checks++;
    if (io_fail !== 1'b0) $display("FAIL clean_fail: got %b want 0", io_fail);
    else passed++;
  endtask

  task automatic test_march_faults();
    int fm[3]   = '{1, 1, 2};
    int ta[3]   = '{2, 0, 3};
    int tb[3]   = '{3, 0, 1};
    int tv[3]   = '{1, 0, 0};
    int se[3]   = '{1, 2, 3};
    int sa[3]   = '{2, 0, 1};
    bit tmo;
    int busy, base, bad;
    for (int s = 0; s < 9; s++) begin
      if (s < 3) begin
        fmode = fm[s];
        fa    = ta[s];
        fb    = tb[s];
        fv    = tv[s][0];
      end else begin
        fmode = int'($urandom_range(1, 2));
        fa    = int'($urandom_range(0, N - 1));
        fb    = (fmode == 1) ? int'($urandom_range(0, DW - 1))
                             : int'($urandom_range(0, N - 1));
        fv    = 1'($urandom_range(0, 1));
      end
      set_mem();
      build_exp();
      do_run(tmo, busy, base);
      checks++;
      if (tmo) $display("FAIL fault%0d_timeout: no done within bound", s);
      else passed++;
      checks++;
      if (io_fail !== exp_fail)
        $display("FAIL fault%0d_flag: got %b want %b", s, io_fail, exp_fail);
      else passed++;
      if (exp_fail) begin
        checks++;
        if (io_fail_elem !== 3'(exp_elem) || io_fail_addr !== 2'(exp_addr))
          $display("FAIL fault%0d_where: got e%0d a%0d want e%0d a%0d",
                   s, io_fail_elem, io_fail_addr, exp_elem, exp_addr);
        else passed++;
      end
      if (s < 3) begin
        checks++;
        if (io_fail_elem !== 3'(se[s]) || io_fail_addr !== 2'(sa[s]))
          $display("FAIL fixed%0d_where: got e%0d a%0d want e%0d a%0d",
                   s, io_fail_elem, io_fail_addr, se[s], sa[s]);
        else passed++;
      end
      checks++;
      if (busy != exp_busy)
        $display("FAIL fault%0d_busy: got %0d want %0d", s, busy, exp_busy);
      else passed++;
      bad = 0;
      if (log_q.size() - base != exp_nops) bad++;
      else
        for (int i = 0; i < exp_nops; i++)
          if (log_q[base+i] !== exp_q[i]) bad++;
      checks++;
      if (bad != 0)
        $display("FAIL fault%0d_ops: got %0d ops (%0d bad) want %0d",
                 s, log_q.size() - base, bad, exp_nops);
      else passed++;
    end
    fmode = 0;
  endtask

  task automatic test_reset_mid_run();
    int b0, c, n0;
    bit tmo, hit;
    int busy, base;
    fmode = 0;
    c   = int'($urandom_range(13, 20));
    b0  = busy_cnt;
    hit = 0;
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (busy_cnt - b0 == c) begin
        hit = 1;
        break;
      end
      tick();
    end
    checks++;
    if (!hit) $display("FAIL midrst_reach: busy %0d want %0d", busy_cnt - b0, c);
    else passed++;
    reset = 1'b1;
    tick();
    checks++;
    if ({RW0_en, io_busy, io_done, io_fail} !== 4'b0)
      $display("FAIL midrst_state: got %b want 0000",
               {RW0_en, io_busy, io_done, io_fail});
    else passed++;
    n0 = log_q.size();
    repeat (3) tick();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (log_q.size() != n0)
      $display("FAIL midrst_ops: got %0d ops want 0", log_q.size() - n0);
    else passed++;
    set_mem();
    do_run(tmo, busy, base);
    checks++;
    if (tmo || busy != 41 || io_fail !== 1'b0)
      $display("FAIL midrst_rerun: got busy %0d fail %b want 41 0",
               busy, io_fail);
    else passed++;
  endtask

  task automatic test_back_to_back();
    bit tmo;
    int busy, base, b0, d0, b1, d1;
    fmode = 1;
    fa    = 1;
    fb    = 5;
    fv    = 1'b1;
    set_mem();
    do_run(tmo, busy, base);
    checks++;
    if (io_fail !== 1'b1) $display("FAIL b2b_pre: got %b want 1", io_fail);
    else passed++;
    fmode = 0;
    b0 = busy_cnt;
    d0 = done_cnt;
    io_start = 1'b1;
    tick();
    io_start = 1'b0;
    checks++;
    if (io_fail !== 1'b0 || io_busy !== 1'b1)
      $display("FAIL b2b_clear: got fail %b busy %b want 0 1",
               io_fail, io_busy);
    else passed++;
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      if (busy_cnt - b0 == 10) io_start = 1'b1;
      else if (busy_cnt - b0 == 11) io_start = 1'b0;
      else if (busy_cnt - b0 == 20) io_start = 1'b1;
      tick();
      if (done_cnt != d0) begin
        tmo = 0;
        break;
      end
    end
    checks++;
    if (tmo || busy_cnt - b0 != 41)
      $display("FAIL b2b_run1: got busy %0d want 41", busy_cnt - b0);
    else passed++;
    b1 = busy_cnt;
    d1 = done_cnt;
    tick();
    checks++;
    if (io_busy !== 1'b0 || io_done !== 1'b0)
      $display("FAIL b2b_idle: got busy %b done %b want 0 0",
               io_busy, io_done);
    else passed++;
    tick();
    io_start = 1'b0;
    checks++;
    if (io_busy !== 1'b1) $display("FAIL b2b_start2: got %b want 1", io_busy);
    else passed++;
    tmo = 1;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (done_cnt != d1) begin
        tmo = 0;
        break;
      end
    end
    checks++;
    if (tmo || busy_cnt - b1 != 41 || io_fail !== 1'b0)
      $display("FAIL b2b_run2: got busy %0d fail %b want 41 0",
               busy_cnt - b1, io_fail);
    else passed++;
    repeat (4) tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_clean();
    test_march_faults();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
